// File: rtl/npu_host_sequencer.sv
// npu_host_sequencer: host-side driver for one NPU invocation per sample.
// Each sample sends six config words, the weight words and the input words,
// waits out the calculation window, then reads the results back onto a
// valid/ready result stream. All outputs are registered except npu_oe.
module npu_host_sequencer #(
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned CALC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        num_layers,
    input  logic [4:0]        num_in,
    input  logic [4:0]        num_h1,
    input  logic [4:0]        num_h2,
    input  logic [4:0]        num_out,
    input  logic [1:0]        act,
    input  logic [CNT_W-1:0]  num_w,
    input  logic [CALC_W-1:0] calc_cycles,
    input  logic [15:0]       num_samples,
    input  logic              src_valid,
    input  logic [31:0]       src_data,
    output logic              src_ready,
    output logic              npu_we,
    output logic              npu_oe,
    output logic [31:0]       npu_data_o,
    output logic              npu_drive,
    input  logic [31:0]       npu_data_i,
    input  logic              npu_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StWgt,
        StInp,
        StGap,
        StCalc,
        StRead,
        StNext
    } state_t;

    state_t state_q;

    // Captured configuration.
    logic [1:0]        num_layers_q;
    logic [4:0]        num_in_q;
    logic [4:0]        num_h1_q;
    logic [4:0]        num_h2_q;
    logic [4:0]        num_out_q;
    logic [1:0]        act_q;
    logic [CNT_W-1:0]  num_w_q;
    logic [CALC_W-1:0] calc_q;
    logic [15:0]       samples_q;

    // Progress counters.
    logic [2:0]        cfg_idx_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [15:0]       sample_cnt_q;
    logic [CALC_W-1:0] calc_cnt_q;
    logic [5:0]        rd_cnt_q;

    // Derived terms.
    logic              src_acc;
    logic [CNT_W-1:0]  word_cnt_nxt;
    logic [CNT_W-1:0]  in_total;
    logic              in_left;
    logic [5:0]        rd_total;
    logic              rd_left;
    logic [CALC_W:0]   calc_cnt_inc;
    logic              calc_done;
    logic              sample_last;
    logic [31:0]       cfg_word;

    localparam logic [CNT_W-1:0]  CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CALC_W-1:0] CalcOne = {{(CALC_W-1){1'b0}}, 1'b1};

    // Handshake, terminal-count and completion terms.
    always_comb begin
        src_acc      = src_valid & src_ready;
        word_cnt_nxt = src_acc ? (word_cnt_q + CntOne) : word_cnt_q;
        in_total     = CNT_W'(num_in_q) + CntOne;
        in_left      = (word_cnt_q != in_total);
        rd_total     = {1'b0, num_out_q} + 6'd1;
        rd_left      = (rd_cnt_q != rd_total);
        // Counter saturates at calc_q, so either equality marks the window as spent.
        calc_cnt_inc = {1'b0, calc_cnt_q} + {1'b0, CalcOne};
        calc_done    = (calc_cnt_q == calc_q) || (calc_cnt_inc == {1'b0, calc_q});
        sample_last  = ((sample_cnt_q + 16'd1) == samples_q);
    end

    // Config word selected by the CFG word index (index 0 is num_layers).
    always_comb begin
        cfg_word = 32'd0;
        case (cfg_idx_q)
            3'd1:    cfg_word = {27'd0, num_in_q};
            3'd2:    cfg_word = {27'd0, num_h1_q};
            3'd3:    cfg_word = {27'd0, num_h2_q};
            3'd4:    cfg_word = {27'd0, num_out_q};
            3'd5:    cfg_word = {30'd0, act_q};
            default: cfg_word = {30'd0, num_layers_q};
        endcase
    end

    // Read strobe stays combinational so a stalled result holds back the next fetch.
    assign npu_oe = (state_q == StRead) && rd_left && (!out_valid || out_ready);

    // Sequencer FSM with registered bus, source and result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            num_layers_q <= 2'd0;
            num_in_q     <= 5'd0;
            num_h1_q     <= 5'd0;
            num_h2_q     <= 5'd0;
            num_out_q    <= 5'd0;
            act_q        <= 2'd0;
            num_w_q      <= '0;
            calc_q       <= '0;
            samples_q    <= 16'd0;
            cfg_idx_q    <= 3'd0;
            word_cnt_q   <= '0;
            sample_cnt_q <= 16'd0;
            calc_cnt_q   <= '0;
            rd_cnt_q     <= 6'd0;
            src_ready    <= 1'b0;
            npu_we       <= 1'b0;
            npu_drive    <= 1'b0;
            npu_data_o   <= 32'd0;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;

            // Result register: load on each read, drop valid once accepted.
            if (npu_oe) begin
                out_data  <= npu_data_i;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        num_layers_q <= num_layers;
                        num_in_q     <= num_in;
                        num_h1_q     <= num_h1;
                        num_h2_q     <= num_h2;
                        num_out_q    <= num_out;
                        act_q        <= act;
                        num_w_q      <= num_w;
                        calc_q       <= calc_cycles;
                        samples_q    <= (num_samples == 16'd0) ? 16'd1 : num_samples;
                        sample_cnt_q <= 16'd0;
                        // Config word 0 goes out on the same edge that captures start.
                        npu_we       <= 1'b1;
                        npu_drive    <= 1'b1;
                        npu_data_o   <= {30'd0, num_layers};
                        cfg_idx_q    <= 3'd1;
                        busy         <= 1'b1;
                        state_q      <= StCfg;
                    end
                end

                StCfg: begin
                    npu_we     <= 1'b1;
                    npu_drive  <= 1'b1;
                    npu_data_o <= cfg_word;
                    cfg_idx_q  <= cfg_idx_q + 3'd1;
                    if (cfg_idx_q == 3'd5) begin
                        // Open the source a cycle early so the first word follows act.
                        word_cnt_q <= '0;
                        src_ready  <= 1'b1;
                        state_q    <= (num_w_q == '0) ? StInp : StWgt;
                    end
                end

                StWgt: begin
                    npu_we    <= src_acc;
                    npu_drive <= src_acc;
                    if (src_acc) begin
                        npu_data_o <= src_data;
                    end
                    // Inputs always follow, so src_ready stays high across the switch.
                    if (word_cnt_nxt == num_w_q) begin
                        word_cnt_q <= '0;
                        state_q    <= StInp;
                    end else begin
                        word_cnt_q <= word_cnt_nxt;
                    end
                end

                StInp: begin
                    if (in_left) begin
                        npu_we     <= src_acc;
                        npu_drive  <= src_acc;
                        if (src_acc) begin
                            npu_data_o <= src_data;
                        end
                        word_cnt_q <= word_cnt_nxt;
                        src_ready  <= (word_cnt_nxt != in_total);
                    end else begin
                        // Last input has just been driven; this edge releases the bus.
                        npu_we    <= 1'b0;
                        npu_drive <= 1'b0;
                        state_q   <= StGap;
                    end
                end

                StGap: begin
                    npu_we     <= 1'b0;
                    npu_drive  <= 1'b0;
                    calc_cnt_q <= '0;
                    rd_cnt_q   <= 6'd0;
                    if ((calc_q == '0) && npu_ready) begin
                        state_q <= StRead;
                    end else begin
                        state_q <= StCalc;
                    end
                end

                StCalc: begin
                    if (calc_cnt_q != calc_q) begin
                        calc_cnt_q <= calc_cnt_q + CalcOne;
                    end
                    if (calc_done && npu_ready) begin
                        state_q <= StRead;
                    end
                end

                StRead: begin
                    if (npu_oe) begin
                        rd_cnt_q <= rd_cnt_q + 6'd1;
                        if ((rd_cnt_q + 6'd1) == rd_total) begin
                            state_q <= StNext;
                        end
                    end
                end

                StNext: begin
                    // Wait for the final result of this sample to be taken.
                    if (!out_valid || out_ready) begin
                        if (sample_last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 16'd1;
                            npu_we       <= 1'b1;
                            npu_drive    <= 1'b1;
                            npu_data_o   <= {30'd0, num_layers_q};
                            cfg_idx_q    <= 3'd1;
                            state_q      <= StCfg;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/npu_host_sequencer.md
# npu_host_sequencer

Host-side sequencer that drives one complete NPU invocation over the NPU's shared 32-bit word bus (`we`/`oe`/`data`/`ready`). It sits directly upstream of `npu` and replaces hand-scripted bus driving. Per sample it sends the six configuration words, the weight words and the input words from a valid/ready source stream. It then waits out the calculation window, reads the output words back and presents them on a valid/ready result stream. It repeats this for a programmed number of samples.

## Interface
- `CNT_W`, 12: width of the weight-count field.
- `CALC_W`, 8: width of the calculation-wait counter.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; latches all config inputs; ignored unless idle.
- `num_layers` in 2, `num_in` in 5, `num_h1` in 5, `num_h2` in 5, `num_out` in 5, `act` in 2: NPU config fields, sent zero-extended to 32 bits. `num_in` and `num_out` are encoded as count-1.
- `num_w` in CNT_W: number of weight/bias words; 0 means no weight phase.
- `calc_cycles` in CALC_W: minimum idle cycles between the last input word and the first read.
- `num_samples` in 16: samples per `start`; 0 is treated as 1.
- `src_valid` in 1, `src_data` in 32, `src_ready` out 1: weight/input word stream (weights first, then inputs, per sample).
- `npu_we` out 1, `npu_oe` out 1: NPU bus strobes.
- `npu_data_o` out 32: NPU bus write data.
- `npu_drive` out 1: tristate enable for `npu_data_o`.
- `npu_data_i` in 32: NPU bus read data.
- `npu_ready` in 1: NPU ready flag.
- `out_valid` out 1, `out_data` out 32, `out_ready` in 1: result stream.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse after the final sample's last result is accepted.

## Operation
- FSM states are IDLE, CFG, WGT, INP, GAP, CALC, READ, NEXT.
- IDLE moves to CFG on `start`. All config inputs are captured into registers at this point; later changes have no effect.
- CFG sends 6 words in this order: num_layers, num_in, num_h1, num_h2, num_out, act. It never stalls.
- WGT transfers `num_w` words from the source. When `num_w`=0, CFG goes straight to INP.
- INP transfers `num_in`+1 words from the source.
- Source handshake:
  - A word is taken on `src_valid & src_ready`.
  - `src_ready` is high only in WGT/INP while words remain; it may assert one cycle early so the stream has no gaps.
  - An accepted word appears on `npu_data_o` with `npu_we`=1 and `npu_drive`=1 the next cycle.
  - A cycle with no accepted word gives `npu_we`=0 on the bus the following cycle; word counters hold.
- GAP lasts 1 cycle with `npu_we`=0 and `npu_drive`=0.
- CALC counts `calc_cycles` cycles (0 means skip the count). It exits to READ once the count is complete and `npu_ready`=1, and waits indefinitely otherwise.
- READ fetches `num_out`+1 words:
  - `npu_oe` = (words remaining) & (!`out_valid` | `out_ready`); this is the only combinational output.
  - `npu_data_i` is captured at the end of each `oe` cycle into `out_data`, with `out_valid`=1 the next cycle.
  - `out_valid` holds until `out_ready`.
- NEXT: if samples remain, go to CFG (config is resent every sample). Otherwise pulse `done` once the last result is accepted, then return to IDLE.
- `npu_we` and `npu_oe` are never high together, and `npu_drive`=0 whenever `npu_oe`=1.
- Reset values:
  - `npu_we`, `npu_oe`, `npu_drive`, `src_ready`, `out_valid`, `busy`, `done` = 0.
  - `npu_data_o`, `out_data` = 0.
  - State is IDLE.
  - Reset asserted mid-operation aborts immediately; the next sample restarts from CFG on a new `start`.
- Counters: the word counter is CNT_W bits and the sample counter is 16 bits. Neither wraps; they are compared to terminal counts.

## Timing
- With `start` at cycle 0, `src_valid` held 1, `out_ready` held 1, `npu_ready`=1 and the inversek2j net (`num_w`=6, `num_in`=1, `num_out`=1, `calc_cycles`=5):
  - Config words are on the bus in cycles 1–6, weights in 7–12 and inputs in 13–14.
  - GAP is cycle 15 and CALC is cycles 16–20.
  - `npu_oe` is high in cycles 21–22; `out_valid` is high in cycles 22–23.
  - `done` pulses in cycle 24 and `busy` falls in cycle 24.
- Back-to-back samples: the next sample's config word 0 appears in the cycle after the last `out_valid` handshake.

## Test plan
- inversek2j single sample with the values above: exact bus sequence 0,1,0,0,1,0, then w0–w5, in0, in1; `we` high in cycles 1–14; two results match the NPU model; `done` at cycle 24.
- Source stall: `src_valid` low for 3 cycles mid-weights; `npu_we` low for exactly 3 bus cycles, no word lost or duplicated, all later events shifted by 3.
- Sink stall: `out_ready` low for 4 cycles on result 0; `npu_oe` drops, `out_data` stable, result 1 is still correct.
- `npu_ready` held low 10 cycles past the `calc_cycles` window; READ starts the cycle after it rises.
- `num_samples`=3, `num_w`=0: three CFG/INP/READ rounds, no WGT phase, a single `done`.
- `rst` low during INP: all outputs 0 the next cycle; a new `start` produces a clean full sequence; `start` pulses while busy are ignored.
